regfile_scoreboard: RTL and testbench
=====================================

Name: regfile_scoreboard

Overview:
- Parametrised successor to the 32x64 LEGv8 register file.
- Width, depth and the hardwired-zero index are configurable.
- Adds a per-register pending (scoreboard) bit. The issue stage marks a destination as awaiting write-back, and write-back clears it.
- Each read port reports whether its operand is ready. The block sits between decode/issue and the write-back stage; the hazard unit uses the ready flags to stall.

Parameters:
- N, 64, data width of each register.
- AW, 5, address width; depth = 2**AW registers.
- ZERO_REG, 31, index of the hardwired-zero register. Set it to 2**AW to disable (no zero register).

Ports:
- clock  input  1  posedge clock.
- reset  input  1  asynchronous, active-low; 0 clears all state.
- D  input  N  write-back data.
- DA  input  AW  write-back destination address.
- W  input  1  write enable.
- SA  input  AW  read address, A port.
- SB  input  AW  read address, B port.
- A  output  N  read data, A port.
- B  output  N  read data, B port.
- A_ready  output  1  operand on A is valid (not pending).
- B_ready  output  1  operand on B is valid.
- MA  input  AW  mark address (destination of newly issued instruction).
- M  input  1  mark enable: set the pending bit of MA.
- busy_count  output  AW+1  number of registers currently pending.

Behaviour:
- Storage: 2**AW registers of N bits, plus a pending bit per register. Register ZERO_REG always reads 0, is never pending, and ignores W and M.
- Reset (reset=0, asynchronous):
  - All registers go to 0 and all pending bits to 0.
  - Consequently A=B=0, A_ready=B_ready=1, busy_count=0.
  - Reset dominates clock. It is effective immediately, including mid-operation; any write or mark in the same cycle is lost.
- Write: on posedge clock with W=1 and DA!=ZERO_REG, reg[DA] <= D and pending[DA] <= 0.
- Mark: on posedge clock with M=1 and MA!=ZERO_REG, pending[MA] <= 1.
- Simultaneous W and M on the same address: the mark wins. Data is written, but pending stays 1, because a younger producer is now outstanding.
- W and M on different addresses are independent and both take effect.
- Read: combinational, with zero latency. A=reg[SA] and A_ready=!pending[SA]; same for B with SB.
- Read of ZERO_REG: returns 0 with ready=1.
- Same-cycle write and read of one address, with WRITE_BYPASS_EN undefined: the old value is returned and ready reflects the current pending bit. The new data is visible the cycle after the edge.
- busy_count: registered. It equals the popcount of the pending bits after each edge and is updated in the same cycle the pending bits change.
  - Per-edge delta is +1, -1 or 0.
  - A mark of an already-pending register does not increment.
  - A write to a non-pending register does not decrement.
  - Same-address W+M when the register is not pending gives +1.
  - It cannot overflow; its maximum is 2**AW or 2**AW-1 with a zero register.

Optional Feature:
- Macro: REGFILE_WRITE_BYPASS_EN.
- Defined: when W=1, DA!=ZERO_REG and SA==DA, A=D and A_ready=1 in the same cycle, before the edge. This holds even if the register is pending, unless M=1 with MA==DA in the same cycle, in which case A_ready=0 and A=D. B is handled identically with SB.
- Undefined: no forwarding; behaviour is as described in Behaviour.

Test Plan:
- Reset pulse low for 2 cycles with W=1, DA=3, D=0xFF: after release, reg3 reads 0, A_ready=B_ready=1, busy_count=0.
- Write 0x0123456789ABCDEF to DA=5 and read SA=5, SB=31 next cycle: A=0x0123456789ABCDEF, B=0. Then write 0xDEAD to DA=31: B remains 0.
- M=1, MA=7 for one cycle: A_ready=0 for SA=7 and busy_count=1. Next cycle W=1, DA=7, D=0x42: after the edge A=0x42, A_ready=1, busy_count=0.
- Same edge with M=1, MA=9 and W=1, DA=9, D=0x11: after the edge reg9=0x11, pending[9]=1, busy_count=1, B_ready=0 for SB=9.
- Mark registers 0..30 on successive cycles, then mark 31: busy_count=31 and the mark on 31 is ignored. Then assert reset mid-sequence: busy_count=0 immediately, without waiting for a clock edge.
- With REGFILE_WRITE_BYPASS_EN: pending reg4, then W=1, DA=4, D=0xAA, SA=4 in the same cycle: A=0xAA and A_ready=1 before the edge. Without the macro: A=old value and A_ready=0 until after the edge.

Source files
------------

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: parametrised register file with a per-register
// pending (scoreboard) bit, placed between decode/issue and write-back.
//   - Issue marks a destination pending (M/MA); write-back (W/DA/D) writes
//     data and clears pending unless a mark hits the same register on the
//     same edge (a younger producer is then outstanding).
//   - Two combinational read ports report data plus an operand-ready flag.
//   - busy_count is a registered popcount of the pending bits.
//   - Register ZERO_REG reads as 0, is never pending and ignores W and M.
//     ZERO_REG = 2**AW means there is no hardwired-zero register.
// Optional feature macro: REGFILE_WRITE_BYPASS_EN
//   When defined, a same-cycle write to the register being read is forwarded
//   to the read port before the clock edge.
// Reset: asynchronous, active-low (reset = 0 clears all state).
module regfile_scoreboard #(
  parameter int N        = 64,
  parameter int AW       = 5,
  parameter int ZERO_REG = 31
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [N-1:0]  D,
  input  logic [AW-1:0] DA,
  input  logic          W,
  input  logic [AW-1:0] SA,
  input  logic [AW-1:0] SB,
  output logic [N-1:0]  A,
  output logic [N-1:0]  B,
  output logic          A_ready,
  output logic          B_ready,
  input  logic [AW-1:0] MA,
  input  logic          M,
  output logic [AW:0]   busy_count
);

  localparam int DEPTH = 2**AW;
  // One extra bit so that ZERO_REG = 2**AW never matches any real address.
  localparam logic [AW:0] ZR_IDX = (AW+1)'(ZERO_REG);
  localparam logic [AW:0] ONE    = (AW+1)'(1);

  function automatic logic is_zero(input logic [AW-1:0] addr);
    return ({1'b0, addr} == ZR_IDX);
  endfunction

  logic [N-1:0]     r_regs [DEPTH];
  logic [DEPTH-1:0] r_pend;
  logic [AW:0]      r_busy_count;

  logic             w_wr_en;
  logic             w_mk_en;
  logic             w_same_addr;
  logic             w_inc;
  logic             w_dec;
  logic [N-1:0]     w_a_data;
  logic [N-1:0]     w_b_data;
  logic             w_a_rdy;
  logic             w_b_rdy;

  // Qualify write and mark; the zero register swallows both.
  always_comb begin
    w_wr_en     = W && !is_zero(DA);
    w_mk_en     = M && !is_zero(MA);
    w_same_addr = (MA == DA);
    // A mark only counts when the register was idle.
    w_inc       = w_mk_en && !r_pend[MA];
    // A write only retires a pending register if no same-address mark
    // re-arms it on this edge.
    w_dec       = w_wr_en && r_pend[DA] && !(w_mk_en && w_same_addr);
  end

  // Data storage: write-back updates the addressed register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) r_regs[i] <= '0;
    end else if (w_wr_en) begin
      r_regs[DA] <= D;
    end
  end

  // Pending bits: write clears, mark sets; the mark is applied last so it
  // wins when both target the same register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_pend <= '0;
    end else begin
      if (w_wr_en) r_pend[DA] <= 1'b0;
      if (w_mk_en) r_pend[MA] <= 1'b1;
    end
  end

  // Busy counter tracks the popcount of the pending bits incrementally;
  // a simultaneous retire and new mark cancel out.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_busy_count <= '0;
    end else if (w_inc && !w_dec) begin
      r_busy_count <= r_busy_count + ONE;
    end else if (w_dec && !w_inc) begin
      r_busy_count <= r_busy_count - ONE;
    end
  end

  // Read ports: combinational lookup, zero register forced to 0/ready,
  // optional same-cycle forwarding of the write-back value.
  always_comb begin
    w_a_data = is_zero(SA) ? '0 : r_regs[SA];
    w_a_rdy  = is_zero(SA) ? 1'b1 : !r_pend[SA];
    w_b_data = is_zero(SB) ? '0 : r_regs[SB];
    w_b_rdy  = is_zero(SB) ? 1'b1 : !r_pend[SB];
`ifdef REGFILE_WRITE_BYPASS_EN
    // Forwarded data is ready unless a younger producer is being issued to
    // the same register in this very cycle.
    if (w_wr_en && (SA == DA)) begin
      w_a_data = D;
      w_a_rdy  = !(w_mk_en && w_same_addr);
    end
    if (w_wr_en && (SB == DA)) begin
      w_b_data = D;
      w_b_rdy  = !(w_mk_en && w_same_addr);
    end
`endif
  end

  assign A          = w_a_data;
  assign B          = w_b_data;
  assign A_ready    = w_a_rdy;
  assign B_ready    = w_b_rdy;
  assign busy_count = r_busy_count;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Testbench for regfile_scoreboard: directed scenarios with literal
// expectations, a randomized phase checked every cycle against a
// behavioural model, and a write/read-back sweep using an expected queue.
module tb_regfile_scoreboard;

  localparam int N     = 64;
  localparam int AW    = 5;
  localparam int DEPTH = 32;
  localparam logic [AW-1:0] ZA = 5'd31;

  logic          clock;
  logic          reset;
  logic [N-1:0]  D;
  logic [AW-1:0] DA, SA, SB, MA;
  logic          W, M;
  logic [N-1:0]  A, B;
  logic          A_ready, B_ready;
  logic [AW:0]   busy_count;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 0;

  logic [N-1:0] exp_q[$];

  // Behavioural model state
  logic [N-1:0] m_reg  [DEPTH];
  bit           m_pend [DEPTH];

  regfile_scoreboard #(.N(N), .AW(AW), .ZERO_REG(31)) dut (
    .clock      (clock),
    .reset      (reset),
    .D          (D),
    .DA         (DA),
    .W          (W),
    .SA         (SA),
    .SB         (SB),
    .A          (A),
    .B          (B),
    .A_ready    (A_ready),
    .B_ready    (B_ready),
    .MA         (MA),
    .M          (M),
    .busy_count (busy_count)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic [N-1:0] m_read_data(input logic [AW-1:0] a);
    if (a == ZA) return '0;
`ifdef REGFILE_WRITE_BYPASS_EN
    if (W && DA != ZA && a == DA) return D;
`endif
    return m_reg[a];
  endfunction

  function automatic logic m_read_ready(input logic [AW-1:0] a);
    if (a == ZA) return 1'b1;
`ifdef REGFILE_WRITE_BYPASS_EN
    if (W && DA != ZA && a == DA) return !(M && MA == DA);
`endif
    return !m_pend[a];
  endfunction

  function automatic int m_busy();
    int c = 0;
    for (int i = 0; i < DEPTH; i++) if (m_pend[i]) c++;
    return c;
  endfunction

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        m_reg[i]  <= '0;
        m_pend[i] <= 1'b0;
      end
    end else begin
      if (W && DA != ZA) begin
        m_reg[DA]  <= D;
        m_pend[DA] <= 1'b0;
      end
      if (M && MA != ZA) m_pend[MA] <= 1'b1;
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clock) begin
    if (chk_en) begin
      check("cmp_A",          A,                m_read_data(SA));
      check("cmp_B",          B,                m_read_data(SB));
      check("cmp_A_ready",    N'(A_ready),      N'(m_read_ready(SA)));
      check("cmp_B_ready",    N'(B_ready),      N'(m_read_ready(SB)));
      check("cmp_busy_count", N'(busy_count),   N'(m_busy()));
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      m_reg[i]  = '0;
      m_pend[i] = 1'b0;
    end
    reset = 1'b0;
    W = 1'b1; DA = 5'd3; D = 64'hFF;
    M = 1'b0; MA = '0; SA = '0; SB = '0;

    // Reset held for two edges with a write pending that must be lost.
    tick();
    tick();
    reset = 1'b1;
    W = 1'b0; SA = 5'd3; SB = 5'd3;
    #1;
    check("rst_reg3",     A,               64'h0);
    check("rst_A_ready",  N'(A_ready),     64'h1);
    check("rst_B_ready",  N'(B_ready),     64'h1);
    check("rst_busy",     N'(busy_count),  64'h0);
    chk_en = 1'b1;

    // Plain write, zero-register read and ignored write to the zero register.
    W = 1'b1; DA = 5'd5; D = 64'h0123456789ABCDEF;
    tick();
    W = 1'b0; SA = 5'd5; SB = 5'd31;
    #1;
    check("wr5_A",        A,               64'h0123456789ABCDEF);
    check("zero_B",       B,               64'h0);
    W = 1'b1; DA = 5'd31; D = 64'hDEAD;
    tick();
    W = 1'b0;
    #1;
    check("zero_wr_B",    B,               64'h0);
    check("zero_B_ready", N'(B_ready),     64'h1);

    // Mark then write-back clears the pending bit.
    M = 1'b1; MA = 5'd7; SA = 5'd7;
    tick();
    M = 1'b0;
    #1;
    check("mark7_ready",  N'(A_ready),     64'h0);
    check("mark7_busy",   N'(busy_count),  64'h1);
    W = 1'b1; DA = 5'd7; D = 64'h42;
    tick();
    W = 1'b0;
    #1;
    check("wb7_A",        A,               64'h42);
    check("wb7_ready",    N'(A_ready),     64'h1);
    check("wb7_busy",     N'(busy_count),  64'h0);

    // Same-edge mark and write: data lands, pending stays set.
    M = 1'b1; MA = 5'd9; W = 1'b1; DA = 5'd9; D = 64'h11; SA = 5'd9; SB = 5'd9;
    tick();
    M = 1'b0; W = 1'b0;
    #1;
    check("wm9_A",        A,               64'h11);
    check("wm9_B_ready",  N'(B_ready),     64'h0);
    check("wm9_busy",     N'(busy_count),  64'h1);
    W = 1'b1; DA = 5'd9; D = 64'h0;
    tick();
    W = 1'b0;

    // Same-cycle write and read of a pending register.
    M = 1'b1; MA = 5'd4;
    tick();
    M = 1'b0; W = 1'b1; DA = 5'd4; D = 64'hAA; SA = 5'd4;
    #1;
`ifdef REGFILE_WRITE_BYPASS_EN
    check("byp_A",        A,               64'hAA);
    check("byp_ready",    N'(A_ready),     64'h1);
`else
    check("nobyp_A",      A,               64'h0);
    check("nobyp_ready",  N'(A_ready),     64'h0);
`endif
    tick();
    W = 1'b0;
    #1;
    check("post4_A",      A,               64'hAA);
    check("post4_ready",  N'(A_ready),     64'h1);
    check("post4_busy",   N'(busy_count),  64'h0);

    // Fill the scoreboard, then reset asynchronously mid-cycle.
    for (int i = 0; i < 31; i++) begin
      M = 1'b1; MA = 5'(i);
      tick();
    end
    MA = 5'd31;
    tick();
    M = 1'b0; SB = 5'd31;
    #1;
    check("full_busy",    N'(busy_count),  64'd31);
    check("full_zero_rdy", N'(B_ready),    64'h1);
    reset = 1'b0;
    #1;
    check("async_busy",   N'(busy_count),  64'h0);
    check("async_A",      A,               64'h0);
    check("async_A_rdy",  N'(A_ready),     64'h1);
    tick();
    reset = 1'b1;

    // Randomized traffic with occasional mid-run resets.
    for (int c = 0; c < 1500; c++) begin
      W  = ($urandom_range(0, 2) != 0);
      M  = ($urandom_range(0, 2) == 0);
      DA = 5'($urandom_range(0, 31));
      MA = ($urandom_range(0, 3) == 0) ? DA : 5'($urandom_range(0, 31));
      SA = ($urandom_range(0, 2) == 0) ? DA : 5'($urandom_range(0, 31));
      SB = ($urandom_range(0, 2) == 0) ? MA : 5'($urandom_range(0, 31));
      D  = {$urandom, $urandom};
      if ($urandom_range(0, 199) == 0) begin
        W = 1'b0; M = 1'b0;
        reset = 1'b0;
        tick();
        reset = 1'b1;
      end else begin
        tick();
      end
    end

    // Write every register, then read each back through the expected queue.
    M = 1'b0;
    for (int a = 0; a < DEPTH; a++) begin
      W = 1'b1; DA = 5'(a); D = {$urandom, $urandom};
      exp_q.push_back((a == 31) ? 64'h0 : D);
      tick();
    end
    W = 1'b0;
    for (int a = 0; a < DEPTH; a++) begin
      SA = 5'(a);
      #1;
      check("readback_A",     A,           exp_q.pop_front());
      check("readback_ready", N'(A_ready), 64'h1);
    end
    check("final_busy", N'(busy_count), 64'h0);

    tick();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
